// File: rtl/alu_share_arb_if.sv
// Request/response/ALU bundle between two requesters and the shared-ALU arbiter.
// slave = arbiter side, master = requesters plus the external combinational ALU.
interface alu_share_arb_if #(
    parameter int DATA_W = 32,
    parameter int CODE_W = 6,
    parameter int TAG_W  = 4,
    parameter int CNT_W  = 16
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [CODE_W-1:0] req0_code;
    logic [CODE_W-1:0] req1_code;
    logic [DATA_W-1:0] req0_op1;
    logic [DATA_W-1:0] req0_op2;
    logic [DATA_W-1:0] req1_op1;
    logic [DATA_W-1:0] req1_op2;
    logic [TAG_W-1:0]  req0_tag;
    logic [TAG_W-1:0]  req1_tag;

    logic [CODE_W-1:0] alu_code;
    logic [DATA_W-1:0] alu_op1;
    logic [DATA_W-1:0] alu_op2;
    logic [DATA_W-1:0] alu_result;
    logic              alu_br_taken;

    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [DATA_W-1:0] rsp0_result;
    logic [DATA_W-1:0] rsp1_result;
    logic              rsp0_br_taken;
    logic              rsp1_br_taken;
    logic [TAG_W-1:0]  rsp0_tag;
    logic [TAG_W-1:0]  rsp1_tag;

    logic [CNT_W-1:0]  gnt_cnt0;
    logic [CNT_W-1:0]  gnt_cnt1;
    logic              busy;

    modport slave (
        input  req_valid, req0_code, req1_code, req0_op1, req0_op2,
               req1_op1, req1_op2, req0_tag, req1_tag,
               alu_result, alu_br_taken, rsp_ready,
        output req_ready, alu_code, alu_op1, alu_op2,
               rsp_valid, rsp0_result, rsp1_result, rsp0_br_taken,
               rsp1_br_taken, rsp0_tag, rsp1_tag, gnt_cnt0, gnt_cnt1, busy
    );

    modport master (
        output req_valid, req0_code, req1_code, req0_op1, req0_op2,
               req1_op1, req1_op2, req0_tag, req1_tag,
               alu_result, alu_br_taken, rsp_ready,
        input  req_ready, alu_code, alu_op1, alu_op2,
               rsp_valid, rsp0_result, rsp1_result, rsp0_br_taken,
               rsp1_br_taken, rsp0_tag, rsp1_tag, gnt_cnt0, gnt_cnt1, busy
    );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin share of one combinational ALU between two requesters.
// Latency: request accepted in cycle N -> response valid in cycle N+1.
// Backpressure: a requester is only granted when its one-entry response buffer is empty or draining.
module alu_share_arb #(
    parameter int DATA_W = 32,
    parameter int CODE_W = 6,
    parameter int TAG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_share_arb_if.slave bus
);

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [TAG_W-1:0]  tag;
    } req_t;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              br_taken;
        logic [TAG_W-1:0]  tag;
    } rsp_t;

    req_t              req [2];
    rsp_t              rsp_q [2];
    logic [1:0]        rsp_vld_q;
    logic [CNT_W-1:0]  cnt_q [2];
    logic              rr_ptr;

    logic [1:0]        eligible;
    logic [1:0]        grant;
    logic              gnt_idx;

    logic [CODE_W-1:0] hold_code;
    logic [DATA_W-1:0] hold_op1;
    logic [DATA_W-1:0] hold_op2;

    assign req[0] = {bus.req0_code, bus.req0_op1, bus.req0_op2, bus.req0_tag};
    assign req[1] = {bus.req1_code, bus.req1_op1, bus.req1_op2, bus.req1_tag};

    // A full buffer that drains this cycle can accept a new result on the same edge.
    always_comb begin
        eligible = bus.req_valid & (~rsp_vld_q | bus.rsp_ready);
        grant    = 2'b00;
        if (eligible == 2'b11) begin
            grant = rr_ptr ? 2'b10 : 2'b01;
        end else begin
            grant = eligible;
        end
        gnt_idx = grant[1];
    end

    assign bus.req_ready = grant;

    // Idle cycles keep the last granted operands on the ALU inputs to avoid toggling.
    always_comb begin
        bus.alu_code = hold_code;
        bus.alu_op1  = hold_op1;
        bus.alu_op2  = hold_op2;
        if (|grant) begin
            bus.alu_code = req[gnt_idx].code;
            bus.alu_op1  = req[gnt_idx].op1;
            bus.alu_op2  = req[gnt_idx].op2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_code <= '0;
            hold_op1  <= '0;
            hold_op2  <= '0;
            rr_ptr    <= 1'b0;
        end else if (|grant) begin
            hold_code <= req[gnt_idx].code;
            hold_op1  <= req[gnt_idx].op1;
            hold_op2  <= req[gnt_idx].op2;
            rr_ptr    <= ~gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_q <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                rsp_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (grant[i]) begin
                    rsp_vld_q[i] <= 1'b1;
                    rsp_q[i]     <= '{result:   bus.alu_result,
                                      br_taken: bus.alu_br_taken,
                                      tag:      req[i].tag};
                end else if (bus.rsp_ready[i]) begin
                    rsp_vld_q[i] <= 1'b0;
                end
                if (grant[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign bus.rsp_valid     = rsp_vld_q;
    assign bus.rsp0_result   = rsp_q[0].result;
    assign bus.rsp1_result   = rsp_q[1].result;
    assign bus.rsp0_br_taken = rsp_q[0].br_taken;
    assign bus.rsp1_br_taken = rsp_q[1].br_taken;
    assign bus.rsp0_tag      = rsp_q[0].tag;
    assign bus.rsp1_tag      = rsp_q[1].tag;
    assign bus.gnt_cnt0      = cnt_q[0];
    assign bus.gnt_cnt1      = cnt_q[1];
    assign bus.busy          = |rsp_vld_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: reset, fairness, backpressure, branches, saturation, idle hold.
// A small behavioural ALU stands in for the shared combinational unit.
module tb_alu_share_arb;

    localparam logic [5:0] ALU_ADD  = 6'd1;
    localparam logic [5:0] ALU_SUB  = 6'd2;
    localparam logic [5:0] ALU_XOR  = 6'd3;
    localparam logic [5:0] ALU_BLT  = 6'd4;
    localparam logic [5:0] ALU_BLTU = 6'd5;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_share_arb_if #(.DATA_W(32), .CODE_W(6), .TAG_W(4), .CNT_W(16)) bus ();
    alu_share_arb_if #(.DATA_W(32), .CODE_W(6), .TAG_W(4), .CNT_W(4))  bus_s ();

    alu_share_arb #(.DATA_W(32), .CODE_W(6), .TAG_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    alu_share_arb #(.DATA_W(32), .CODE_W(6), .TAG_W(4), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        bus.alu_result   = '0;
        bus.alu_br_taken = 1'b0;
        case (bus.alu_code)
            ALU_ADD:  bus.alu_result = bus.alu_op1 + bus.alu_op2;
            ALU_SUB:  bus.alu_result = bus.alu_op1 - bus.alu_op2;
            ALU_XOR:  bus.alu_result = bus.alu_op1 ^ bus.alu_op2;
            ALU_BLT:  bus.alu_br_taken = ($signed(bus.alu_op1) < $signed(bus.alu_op2));
            ALU_BLTU: bus.alu_br_taken = (bus.alu_op1 < bus.alu_op2);
            default:  bus.alu_result = '0;
        endcase
    end

    assign bus_s.alu_result   = '0;
    assign bus_s.alu_br_taken = 1'b0;

    task automatic idle_inputs();
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        bus.req0_code = '0; bus.req0_op1 = '0; bus.req0_op2 = '0; bus.req0_tag = '0;
        bus.req1_code = '0; bus.req1_op1 = '0; bus.req1_op2 = '0; bus.req1_tag = '0;
        bus_s.req_valid = 2'b00;
        bus_s.rsp_ready = 2'b00;
        bus_s.req0_code = '0; bus_s.req0_op1 = '0; bus_s.req0_op2 = '0; bus_s.req0_tag = '0;
        bus_s.req1_code = '0; bus_s.req1_op1 = '0; bus_s.req1_op2 = '0; bus_s.req1_tag = '0;
    endtask

    task automatic drive0(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        bus.req0_code = c; bus.req0_op1 = a; bus.req0_op2 = b; bus.req0_tag = t;
    endtask

    task automatic drive1(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        bus.req1_code = c; bus.req1_op1 = a; bus.req1_op2 = b; bus.req1_tag = t;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b exp 00", bus.rsp_valid); end
        checks++; if (bus.gnt_cnt0 !== 16'd0) begin errors++; $display("FAIL reset_gnt_cnt0 got %0d exp 0", bus.gnt_cnt0); end
        checks++; if (bus.gnt_cnt1 !== 16'd0) begin errors++; $display("FAIL reset_gnt_cnt1 got %0d exp 0", bus.gnt_cnt1); end
        checks++; if (bus.rsp0_result !== 32'd0) begin errors++; $display("FAIL reset_rsp0_result got %h exp 0", bus.rsp0_result); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        bus.rsp_ready = 2'b00;
        drive0(ALU_ADD, 32'd1, 32'd1, 4'd1);
        drive1(ALU_ADD, 32'd2, 32'd2, 4'd2);
        bus.req_valid = 2'b11;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (bus.rsp_valid !== 2'b11) begin errors++; $display("FAIL mid_load_rsp_valid got %b exp 11", bus.rsp_valid); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_load_busy got %b exp 1", bus.busy); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL mid_reset_rsp_valid got %b exp 00", bus.rsp_valid); end
        checks++; if (bus.gnt_cnt0 !== 16'd0 || bus.gnt_cnt1 !== 16'd0) begin
            errors++; $display("FAIL mid_reset_cnt got %0d/%0d exp 0/0", bus.gnt_cnt0, bus.gnt_cnt1);
        end
        bus.req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive1(ALU_ADD, 32'd5, 32'd7, 4'd3);
        bus.rsp_ready = 2'b11;
        bus.req_valid = 2'b10;
        @(negedge clk);
        checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL post_reset_req_ready got %b exp 10", bus.req_ready); end
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        checks++; if (bus.rsp1_result !== 32'd12) begin errors++; $display("FAIL post_reset_result got %0d exp 12", bus.rsp1_result); end
        checks++; if (bus.rsp1_tag !== 4'd3) begin errors++; $display("FAIL post_reset_tag got %0d exp 3", bus.rsp1_tag); end
        checks++; if (bus.rsp_valid !== 2'b10) begin errors++; $display("FAIL post_reset_rsp_valid got %b exp 10", bus.rsp_valid); end
    endtask

    task automatic test_fairness();
        logic [1:0] exp_rdy;
        apply_reset();
        drive0(ALU_SUB, 32'd10, 32'd3, 4'd1);
        drive1(ALU_XOR, 32'hF0, 32'h0F, 4'd2);
        bus.rsp_ready = 2'b11;
        bus.req_valid = 2'b11;
        for (int k = 0; k < 8; k++) begin
            exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            checks++; if (bus.req_ready !== exp_rdy) begin
                errors++; $display("FAIL rr_grant cyc %0d got %b exp %b", k, bus.req_ready, exp_rdy);
            end
            @(posedge clk); #1;
            if (k % 2 == 0) begin
                checks++; if (bus.rsp0_result !== 32'd7) begin errors++; $display("FAIL rr_sub_result got %h exp 7", bus.rsp0_result); end
            end else begin
                checks++; if (bus.rsp1_result !== 32'hFF) begin errors++; $display("FAIL rr_xor_result got %h exp ff", bus.rsp1_result); end
            end
        end
        bus.req_valid = 2'b00;
        checks++; if (bus.gnt_cnt0 !== 16'd4) begin errors++; $display("FAIL rr_gnt_cnt0 got %0d exp 4", bus.gnt_cnt0); end
        checks++; if (bus.gnt_cnt1 !== 16'd4) begin errors++; $display("FAIL rr_gnt_cnt1 got %0d exp 4", bus.gnt_cnt1); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        drive0(ALU_SUB, 32'd10, 32'd3, 4'd1);
        drive1(ALU_XOR, 32'hF0, 32'h0F, 4'd2);
        bus.rsp_ready = 2'b10;
        bus.req_valid = 2'b11;
        @(negedge clk);
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL bp_first_grant got %b exp 01", bus.req_ready); end
        @(posedge clk); #1;
        checks++; if (bus.rsp0_result !== 32'd7) begin errors++; $display("FAIL bp_first_result got %0d exp 7", bus.rsp0_result); end
        drive0(ALU_ADD, 32'd1, 32'd2, 4'd9);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if (bus.req_ready !== 2'b10) begin
                errors++; $display("FAIL bp_stall_grant cyc %0d got %b exp 10", k, bus.req_ready);
            end
            @(posedge clk); #1;
            checks++; if (bus.rsp1_result !== 32'hFF) begin errors++; $display("FAIL bp_req1_result got %h exp ff", bus.rsp1_result); end
        end
        checks++; if (bus.rsp0_result !== 32'd7 || bus.rsp_valid[0] !== 1'b1) begin
            errors++; $display("FAIL bp_held_buffer got %0d/%b exp 7/1", bus.rsp0_result, bus.rsp_valid[0]);
        end
        bus.rsp_ready = 2'b11;
        @(negedge clk);
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL bp_release_grant got %b exp 01", bus.req_ready); end
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        checks++; if (bus.rsp0_result !== 32'd3 || bus.rsp0_tag !== 4'd9) begin
            errors++; $display("FAIL bp_reload got %0d tag %0d exp 3 tag 9", bus.rsp0_result, bus.rsp0_tag);
        end
        checks++; if (bus.rsp_valid[0] !== 1'b1) begin errors++; $display("FAIL bp_reload_valid got %b exp 1", bus.rsp_valid[0]); end
        checks++; if (bus.gnt_cnt0 !== 16'd2 || bus.gnt_cnt1 !== 16'd2) begin
            errors++; $display("FAIL bp_counts got %0d/%0d exp 2/2", bus.gnt_cnt0, bus.gnt_cnt1);
        end
    endtask

    task automatic test_branch();
        bus.rsp_ready = 2'b11;
        drive0(ALU_BLT, 32'hFFFF_FFFF, 32'd1, 4'd4);
        bus.req_valid = 2'b01;
        @(posedge clk); #1;
        checks++; if (bus.rsp0_br_taken !== 1'b1) begin errors++; $display("FAIL blt_taken got %b exp 1", bus.rsp0_br_taken); end
        checks++; if (bus.rsp0_result !== 32'd0) begin errors++; $display("FAIL blt_result got %h exp 0", bus.rsp0_result); end
        drive0(ALU_BLTU, 32'hFFFF_FFFF, 32'd1, 4'd5);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        checks++; if (bus.rsp0_br_taken !== 1'b0) begin errors++; $display("FAIL bltu_taken got %b exp 0", bus.rsp0_br_taken); end
        checks++; if (bus.rsp0_tag !== 4'd5) begin errors++; $display("FAIL bltu_tag got %0d exp 5", bus.rsp0_tag); end
    endtask

    task automatic test_idle_hold();
        bus.rsp_ready = 2'b00;
        bus.req_valid = 2'b00;
        drive0(ALU_ADD, 32'h1234, 32'h5678, 4'd0);
        drive1(ALU_SUB, 32'h9999, 32'h1111, 4'd0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checks++; if (bus.alu_code !== ALU_BLTU || bus.alu_op1 !== 32'hFFFF_FFFF || bus.alu_op2 !== 32'd1) begin
                errors++; $display("FAIL idle_alu_hold cyc %0d got %0d %h %h exp 5 ffffffff 1", k, bus.alu_code, bus.alu_op1, bus.alu_op2);
            end
            checks++; if (bus.rsp_valid !== 2'b01) begin errors++; $display("FAIL idle_rsp_valid cyc %0d got %b exp 01", k, bus.rsp_valid); end
        end
        bus.rsp_ready = 2'b11;
        bus.req_valid = 2'b11;
        @(negedge clk);
        checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL idle_rr_ptr got %b exp 10", bus.req_ready); end
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
    endtask

    task automatic test_saturation();
        bus_s.rsp_ready = 2'b11;
        bus_s.req_valid = 2'b10;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 10) begin
                checks++; if (bus_s.gnt_cnt1 !== 4'd10) begin errors++; $display("FAIL sat_cnt_10 got %0d exp 10", bus_s.gnt_cnt1); end
            end
            if (k == 15) begin
                checks++; if (bus_s.gnt_cnt1 !== 4'd15) begin errors++; $display("FAIL sat_cnt_15 got %0d exp 15", bus_s.gnt_cnt1); end
            end
        end
        bus_s.req_valid = 2'b00;
        checks++; if (bus_s.gnt_cnt1 !== 4'd15) begin errors++; $display("FAIL sat_cnt_20 got %0d exp 15", bus_s.gnt_cnt1); end
        checks++; if (bus_s.gnt_cnt0 !== 4'd0) begin errors++; $display("FAIL sat_cnt0 got %0d exp 0", bus_s.gnt_cnt0); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_reset_midstream();
        test_saturation();
        test_fairness();
        test_backpressure();
        test_branch();
        test_idle_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
